// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch controller.
// The state encoding is fixed because other tools decode it from the bus.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_CLEARING = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [7:0] BCD_MAX_DEFAULT = 8'h99;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command, chain-feedback and display signals between the buttons, the controller and the counter chain.
// The master side issues commands and returns the chain value; the slave side is the controller.
interface bcd_stopwatch_ctrl_if;
    logic       START;
    logic       STOP;
    logic       ZERO;
    logic       LAP;
    logic [7:0] Q;
    logic       CNT_CE;
    logic       CNT_CLR;
    logic [7:0] DISP;
    logic       RUN;
    logic       HOLD;
    logic       OVF;

    modport master (
        output START, STOP, ZERO, LAP, Q,
        input  CNT_CE, CNT_CLR, DISP, RUN, HOLD, OVF
    );

    modport slave (
        input  START, STOP, ZERO, LAP, Q,
        output CNT_CE, CNT_CLR, DISP, RUN, HOLD, OVF
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count of each period.
// Dropping en clears the count, so every re-enable starts a full period.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic CLR,
    input  logic en,
    output logic tick
);
    localparam int             PW      = $clog2(DIV);
    localparam logic [PW-1:0]  PC_LAST = PW'(DIV - 1);

    logic [PW-1:0] pc_reg;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc_reg <= '0;
        end else if (!en || pc_reg == PC_LAST) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_reg + PW'(1);
        end
    end

    assign tick = en && (pc_reg == PC_LAST);
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: turns button commands into count-enable ticks and clear pulses
// for a cascaded BCD chain, stops at the terminal value and keeps a lap-hold display.
module bcd_stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int         DIV     = 10,
    parameter logic [7:0] BCD_MAX = BCD_MAX_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 CLR,
    bcd_stopwatch_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_RUN      = ST_RUN;
    localparam logic [2:0] S_PAUSE    = ST_PAUSE;
    localparam logic [2:0] S_CLEARING = ST_CLEARING;
    localparam logic [2:0] S_DONE     = ST_DONE;

    logic [2:0] state_reg, state_next;
    logic       hold_reg, hold_next;
    logic       cnt_ce_next;
    logic       cnt_ce_reg, cnt_clr_reg, run_reg, ovf_reg;
    logic [7:0] lap_reg, disp_reg;
    logic       tick;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .CLK  (CLK),
        .CLR  (CLR),
        .en   (state_reg == S_RUN),
        .tick (tick)
    );

    // Each state only reacts to the highest-priority command that is meaningful there.
    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        cnt_ce_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.ZERO)       state_next = S_CLEARING;
                else if (bus.START) state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.ZERO) begin
                    state_next = S_CLEARING;
                end else if (bus.STOP) begin
                    state_next = S_PAUSE;
                end else begin
                    if (bus.LAP) hold_next = ~hold_reg;
                    if (tick) begin
                        if (bus.Q == BCD_MAX) state_next  = S_DONE;
                        else                  cnt_ce_next = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.ZERO)       state_next = S_CLEARING;
                else if (bus.START) state_next = S_RUN;
                else if (bus.LAP)   hold_next  = ~hold_reg;
            end
            S_CLEARING: state_next = S_IDLE;
            S_DONE: begin
                if (bus.ZERO) state_next = S_CLEARING;
            end
            default: state_next = S_IDLE;
        endcase
        if (state_next == S_CLEARING) hold_next = 1'b0;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_reg   <= S_IDLE;
            hold_reg    <= 1'b0;
            lap_reg     <= 8'h00;
            disp_reg    <= 8'h00;
            cnt_ce_reg  <= 1'b0;
            cnt_clr_reg <= 1'b0;
            run_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            if (hold_next && !hold_reg) lap_reg <= bus.Q;
            disp_reg    <= hold_reg ? lap_reg : bus.Q;
            cnt_ce_reg  <= cnt_ce_next;
            cnt_clr_reg <= (state_next == S_CLEARING);
            run_reg     <= (state_next == S_RUN);
            ovf_reg     <= (state_next == S_DONE);
        end
    end

    assign bus.CNT_CE  = cnt_ce_reg;
    assign bus.CNT_CLR = cnt_clr_reg;
    assign bus.DISP    = disp_reg;
    assign bus.RUN     = run_reg;
    assign bus.HOLD    = hold_reg;
    assign bus.OVF     = ovf_reg;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for the stopwatch controller, with a behavioural two-digit BCD chain
// closing the loop from CNT_CE/CNT_CLR back to Q.
module tb_bcd_stopwatch_ctrl;
    localparam int DIV = 2;

    logic CLK;
    logic CLR;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ce_cnt   = 0;
    int   clr_cnt  = 0;
    int   ce0, clr0;
    logic [7:0] q_d;

    bcd_stopwatch_ctrl_if bus();

    bcd_stopwatch_ctrl #(.DIV(DIV), .BCD_MAX(8'h99)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Counter chain: Q follows CNT_CE one cycle later, CNT_CLR clears it.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            bus.Q <= 8'h00;
            q_d   <= 8'h00;
        end else begin
            q_d <= bus.Q;
            if (bus.CNT_CLR)     bus.Q <= 8'h00;
            else if (bus.CNT_CE) bus.Q <= bcd_inc(bus.Q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR && bus.CNT_CE)  ce_cnt  <= ce_cnt + 1;
        if (!CLR && bus.CNT_CLR) clr_cnt <= clr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmd(input logic start, input logic stop, input logic zero, input logic lap);
        bus.START = start;
        bus.STOP  = stop;
        bus.ZERO  = zero;
        bus.LAP   = lap;
        step();
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.ZERO  = 1'b0;
        bus.LAP   = 1'b0;
        $display("[%0t] cmd start=%b stop=%b zero=%b lap=%b -> run=%b hold=%b ovf=%b q=%h disp=%h",
                 $time, start, stop, zero, lap, bus.RUN, bus.HOLD, bus.OVF, bus.Q, bus.DISP);
    endtask

    task automatic wait_q(input logic [7:0] target, input int bound, input string tag);
        for (int i = 0; i < bound && bus.Q !== target; i++) step();
        check(tag, bus.Q, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ce"},   bus.CNT_CE,  0);
        check({tag, "_clr"},  bus.CNT_CLR, 0);
        check({tag, "_disp"}, bus.DISP,    0);
        check({tag, "_run"},  bus.RUN,     0);
        check({tag, "_hold"}, bus.HOLD,    0);
        check({tag, "_ovf"},  bus.OVF,     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        CLR = 1'b1;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.ZERO  = 1'b0;
        bus.LAP   = 1'b0;
        #2;
        check_reset_values("reset");
        step();
        CLR = 1'b0;
        step();
        check("idle_run", bus.RUN, 0);

        // Ticks every DIV cycles after START, display lags the enable by two.
        cmd(1, 0, 0, 0);
        check("start_run", bus.RUN, 1);
        check("start_ce0", bus.CNT_CE, 0);
        step(); check("ce_c1", bus.CNT_CE, 0);
        step(); check("ce_c2", bus.CNT_CE, 1);
        step(); check("ce_c3", bus.CNT_CE, 0);
        check("disp_c3", bus.DISP, 8'h00);
        step(); check("ce_c4", bus.CNT_CE, 1);
        check("disp_c4", bus.DISP, 8'h01);
        step(); check("ce_c5", bus.CNT_CE, 0);
        step(); check("ce_c6", bus.CNT_CE, 1);
        check("disp_c6", bus.DISP, 8'h02);
        step();

        // STOP lands on a due tick: no enable, value holds at 03.
        cmd(0, 1, 0, 0);
        check("stop_ce", bus.CNT_CE, 0);
        check("stop_run", bus.RUN, 0);
        step(); step();
        check("pause_q", bus.Q, 8'h03);
        check("pause_disp", bus.DISP, 8'h03);
        check("pause_ticks", ce_cnt, 3);
        cmd(1, 0, 0, 0);
        check("resume_ce0", bus.CNT_CE, 0);
        step(); check("resume_ce1", bus.CNT_CE, 0);
        step(); check("resume_ce2", bus.CNT_CE, 1);

        // Lap hold freezes the display at 12 while the chain runs on.
        wait_q(8'h12, 100, "reach_12");
        cmd(0, 0, 0, 1);
        check("lap_hold_on", bus.HOLD, 1);
        wait_q(8'h15, 100, "reach_15");
        check("lap_disp", bus.DISP, 8'h12);
        cmd(0, 0, 0, 1);
        check("lap_hold_off", bus.HOLD, 0);
        step(); step();
        check("live_disp", bus.DISP, q_d);
        check("live_ge15", bus.DISP >= 8'h15, 1);

        // ZERO outranks STOP and LAP; hold drops and a single clear pulse is issued.
        cmd(0, 0, 0, 1);
        check("hold_again", bus.HOLD, 1);
        clr0 = clr_cnt;
        cmd(0, 1, 1, 1);
        check("zero_hold", bus.HOLD, 0);
        check("zero_clr", bus.CNT_CLR, 1);
        check("zero_run", bus.RUN, 0);
        check("zero_ce", bus.CNT_CE, 0);
        step();
        check("clr_one_cycle", bus.CNT_CLR, 0);
        step(); step();
        check("clr_pulses", clr_cnt - clr0, 1);
        check("zero_q", bus.Q, 8'h00);
        check("zero_disp", bus.DISP, 8'h00);

        // Run to the terminal value: no wrap, DONE ignores everything but ZERO.
        cmd(1, 0, 0, 0);
        wait_q(8'h99, 400, "reach_99");
        ce0 = ce_cnt;
        step();
        check("term_ce", bus.CNT_CE, 0);
        check("term_ovf", bus.OVF, 1);
        check("term_run", bus.RUN, 0);
        step(); step(); step();
        cmd(1, 0, 0, 0);
        check("done_start_ovf", bus.OVF, 1);
        check("done_start_run", bus.RUN, 0);
        cmd(0, 0, 0, 1);
        check("done_lap_hold", bus.HOLD, 0);
        check("done_no_ce", ce_cnt - ce0, 0);
        check("done_q", bus.Q, 8'h99);
        cmd(0, 0, 1, 0);
        check("done_zero_clr", bus.CNT_CLR, 1);
        check("done_zero_ovf", bus.OVF, 0);
        step();
        check("done_clr_end", bus.CNT_CLR, 0);
        step();
        check("done_disp", bus.DISP, 8'h00);

        // Asynchronous reset mid-run.
        cmd(1, 0, 0, 0);
        wait_q(8'h07, 100, "reach_07");
        #2 CLR = 1'b1;
        #1 check_reset_values("async");
        step();
        CLR = 1'b0;
        ce0 = ce_cnt;
        repeat (6) step();
        check("post_rst_ce", ce_cnt - ce0, 0);
        check("post_rst_run", bus.RUN, 0);
        cmd(1, 0, 0, 0);
        step(); step();
        check("post_rst_tick", bus.CNT_CE, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
